hash_tx_scheduler: RTL and testbench
====================================

// Module: hash_tx_scheduler
// PURPOSE
//  Shares one string-hash engine between two character sources. Arbitrates at string
//  granularity with round-robin priority, holding the grant until the source's 'last'
//  character. Clears the engine, streams the granted string into it one byte per beat,
//  and captures the resulting hash into a tagged result register for transmission.
// PARAMETERS
//  CW        8   character width (ASCII byte)
//  HW        8   hash width returned by the engine
//  HASH_LAT  1   cycles from the final eng_valid beat until eng_hash is valid (>=1)
//  MAX_LEN   16  max characters forwarded per string; longer strings are truncated
//  LW        $clog2(MAX_LEN+1)  derived width of the length fields
// PORTS
//  Clock       in   1    single rising-edge clock
//  Reset       in   1    asynchronous, active-high reset
//  req0_valid  in   1    source 0 presents a character
//  req0_char   in   CW   source 0 character
//  req0_last   in   1    source 0 character is the end of its string
//  req0_ready  out  1    scheduler accepts the source 0 character this cycle
//  req1_*      (same four signals for source 1)
//  eng_clr     out  1    one-cycle pulse that clears the engine's running hash
//  eng_valid   out  1    eng_char is a string character this cycle
//  eng_char    out  CW   character to the engine
//  eng_hash    in   HW   running hash from the engine
//  res_valid   out  1    one-cycle pulse: the res_* fields are new
//  res_hash    out  HW   captured hash
//  res_id      out  1    source that produced the result
//  res_len     out  LW   number of characters forwarded to the engine
//  res_trunc   out  1    string exceeded MAX_LEN
//  busy        out  1    high in every state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0. Internal state: state=IDLE, len=0, last_id=1, so
//    source 0 wins the first tie.
//  All outputs are registered, except reqN_ready, which decodes from state and grant.
//  States: IDLE -> CLR -> STREAM -> [DRAIN] -> WAIT -> IDLE.
//  IDLE: if either reqN_valid is high, set gnt. When only one source is valid, that
//    source gets the grant. When both are valid, gnt = ~last_id. Then go to CLR.
//  CLR: eng_clr=1 for exactly one cycle. Set len=0, res_trunc=0. Go to STREAM.
//  STREAM: req[gnt]_ready=1 and req[~gnt]_ready=0.
//    An accepted beat (valid & ready) registers eng_valid=1 and eng_char=char on the
//      next cycle, and increments len.
//    valid low: stall; eng_valid=0 and the grant is held indefinitely.
//    Accepted beat with last=1: go to WAIT.
//    Accepted beat without last that makes len==MAX_LEN: set res_trunc=1, go to DRAIN.
//    If one beat has both last=1 and len==MAX_LEN, the string is not truncated (res_trunc=0).
//  DRAIN: req[gnt]_ready=1. Accepted characters are discarded (eng_valid=0).
//    The accepted beat with last=1 moves the state to WAIT.
//  WAIT: count HASH_LAT cycles from the final eng_valid beat, then:
//    - sample eng_hash into res_hash; set res_id=gnt, res_len=len;
//    - pulse res_valid for 1 cycle; set last_id=gnt; go to IDLE.
//    Between the WAIT entry and the res_valid pulse, both readys are 0.
//  res_* fields hold their values until the next res_valid pulse.
//  The earliest new grant is in the IDLE cycle that follows res_valid.
//  eng_valid never asserts outside STREAM. eng_clr never asserts during a string.
//  Reset mid-string asynchronously returns the block to IDLE and drops all outputs.
//    The partial string is not reported, and the next grant re-clears the engine.
//  An empty string cannot occur, since 'last' always rides on a character.
// TESTING
//  1 req0 sends "APPLES" (last on 'S'), req1 idle -> eng_clr pulse, then A,P,P,L,E,S
//    on eng_valid -> res_valid with id=0, len=6, trunc=0, hash=eng_hash HASH_LAT after 'S'.
//  2 Right after reset, req0="ORANGES" and req1="BANANAS" both valid -> req0 served
//    first and req1 second. With both then valid again, req0 is granted again.
//  3 req0 streams strings back to back while req1 waits -> grants alternate 0,1,0.
//    No character from req1 is accepted while req0 is granted.
//  4 MAX_LEN=16, 20-char string -> 16 eng_valid beats and 4 drained beats.
//    Result: len=16, trunc=1.
//  5 "ZT" with req0_valid low for 3 cycles between chars -> eng_valid low while stalled.
//    Result: len=2, grant held throughout.
//  6 Reset asserted mid-"BANANAS" -> all outputs 0 immediately, no res_valid.
//    A new string afterwards gets a fresh eng_clr and a correct hash.

Source files
------------

// File: rtl/hash_tx_scheduler.sv
// Round-robin scheduler that shares one string-hash engine between two character
// sources, streaming whole strings and capturing a tagged, length-annotated result.
module hash_tx_scheduler #(
    parameter int CW       = 8,
    parameter int HW       = 8,
    parameter int HASH_LAT = 1,
    parameter int MAX_LEN  = 16,
    parameter int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_valid_i,
    input  logic [CW-1:0] req0_char_i,
    input  logic          req0_last_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [CW-1:0] req1_char_i,
    input  logic          req1_last_i,
    output logic          req1_ready_o,
    output logic          eng_clr_o,
    output logic          eng_valid_o,
    output logic [CW-1:0] eng_char_o,
    input  logic [HW-1:0] eng_hash_i,
    output logic          res_valid_o,
    output logic [HW-1:0] res_hash_o,
    output logic          res_id_o,
    output logic [LW-1:0] res_len_o,
    output logic          res_trunc_o,
    output logic          busy_o
);
    localparam int CNTW = (HASH_LAT < 1) ? 1 : $clog2(HASH_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, WAIT} state_t;

    state_t          state_q;
    logic            gnt_q;
    logic            last_id_q;
    logic            trunc_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   len_d;
    logic [CNTW-1:0] cnt_q;
    logic            eng_clr_q;
    logic            eng_valid_q;
    logic [CW-1:0]   eng_char_q;
    logic            res_valid_q;
    logic [HW-1:0]   res_hash_q;
    logic            res_id_q;
    logic [LW-1:0]   res_len_q;
    logic            res_trunc_q;
    logic            busy_q;

    logic            accepting;
    logic            acc;
    logic            acc_last;
    logic [CW-1:0]   acc_char;

    always_comb begin
        accepting    = (state_q == STREAM) || (state_q == DRAIN);
        req0_ready_o = accepting & ~gnt_q;
        req1_ready_o = accepting & gnt_q;
        acc          = gnt_q ? (req1_valid_i & req1_ready_o) : (req0_valid_i & req0_ready_o);
        acc_last     = gnt_q ? req1_last_i : req0_last_i;
        acc_char     = gnt_q ? req1_char_i : req0_char_i;
        len_d        = len_q + LW'(1);
    end

    // The truncation flag is tracked internally so res_trunc_o only changes with res_valid_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_id_q   <= 1'b1;
            trunc_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            eng_clr_q   <= 1'b0;
            eng_valid_q <= 1'b0;
            eng_char_q  <= '0;
            res_valid_q <= 1'b0;
            res_hash_q  <= '0;
            res_id_q    <= 1'b0;
            res_len_q   <= '0;
            res_trunc_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            eng_clr_q   <= 1'b0;
            eng_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_valid_i | req1_valid_i) begin
                        gnt_q     <= (req0_valid_i & req1_valid_i) ? ~last_id_q : req1_valid_i;
                        eng_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= CLR;
                    end
                end
                CLR: begin
                    len_q   <= '0;
                    trunc_q <= 1'b0;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (acc) begin
                        eng_valid_q <= 1'b1;
                        eng_char_q  <= acc_char;
                        len_q       <= len_d;
                        cnt_q       <= '0;
                        if (acc_last) begin
                            state_q <= WAIT;
                        end else if (len_d == LW'(MAX_LEN)) begin
                            trunc_q <= 1'b1;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (acc && acc_last) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNTW'(HASH_LAT)) begin
                        res_valid_q <= 1'b1;
                        res_hash_q  <= eng_hash_i;
                        res_id_q    <= gnt_q;
                        res_len_q   <= len_q;
                        res_trunc_q <= trunc_q;
                        last_id_q   <= gnt_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eng_clr_o   = eng_clr_q;
    assign eng_valid_o = eng_valid_q;
    assign eng_char_o  = eng_char_q;
    assign res_valid_o = res_valid_q;
    assign res_hash_o  = res_hash_q;
    assign res_id_o    = res_id_q;
    assign res_len_o   = res_len_q;
    assign res_trunc_o = res_trunc_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_hash_tx_scheduler.sv
// Bench for hash_tx_scheduler: table vectors, hand sequences and random strings,
// checked against a string-level round-robin model and a multiply-add hash engine.
module tb_hash_tx_scheduler;
    localparam int CW = 8, HW = 8, HASH_LAT = 1, MAX_LEN = 16;
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef byte unsigned bytes_t[$];
    typedef struct { byte unsigned c; bit last; int stall; } drv_t;
    typedef struct { logic [HW-1:0] hash; logic id; logic [LW-1:0] len; logic trunc; } res_t;
    typedef struct { int id; string s; int stall; logic [LW-1:0] exp_len; logic exp_trunc; } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld [2];
    logic [CW-1:0] chr [2];
    logic          lst [2];
    logic          rdy [2];
    logic          eng_clr, eng_valid, res_valid, res_id, res_trunc, busy;
    logic [CW-1:0] eng_char;
    logic [HW-1:0] res_hash;
    logic [LW-1:0] res_len;
    logic [HW-1:0] eng_h = '0;

    int   checks = 0;
    int   errors = 0;
    drv_t dq0[$], dq1[$];
    res_t e0[$], e1[$];
    logic obs_id[$];
    res_t last_res;
    res_t m_x;
    logic m_id;
    logic m_last_id = 1'b1;
    int   got_len = 0;
    int   clr_cnt = 0;
    vec_t tbl[6];

    hash_tx_scheduler #(.CW(CW), .HW(HW), .HASH_LAT(HASH_LAT), .MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(vld[0]), .req0_char_i(chr[0]), .req0_last_i(lst[0]), .req0_ready_o(rdy[0]),
        .req1_valid_i(vld[1]), .req1_char_i(chr[1]), .req1_last_i(lst[1]), .req1_ready_o(rdy[1]),
        .eng_clr_o(eng_clr), .eng_valid_o(eng_valid), .eng_char_o(eng_char), .eng_hash_i(eng_h),
        .res_valid_o(res_valid), .res_hash_o(res_hash), .res_id_o(res_id),
        .res_len_o(res_len), .res_trunc_o(res_trunc), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Engine: h = h*31 + c, result visible one cycle after the beat.
    always @(posedge clk) begin
        if (eng_clr) eng_h <= '0;
        else if (eng_valid) eng_h <= eng_h * 8'd31 + eng_char;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t expect_of(input bytes_t b);
        res_t r;
        int   n = b.size();
        r.len   = LW'((n > MAX_LEN) ? MAX_LEN : n);
        r.trunc = (n > MAX_LEN);
        r.id    = 1'b0;
        r.hash  = '0;
        for (int i = 0; i < int'(r.len); i++) r.hash = r.hash * 8'd31 + b[i];
        return r;
    endfunction

    task automatic push_bytes(input int id, input bytes_t b, input int stall);
        drv_t d;
        res_t r = expect_of(b);
        for (int i = 0; i < b.size(); i++) begin
            d.c = b[i]; d.last = (i == b.size() - 1); d.stall = (i == 0) ? 0 : stall;
            if (id == 0) dq0.push_back(d); else dq1.push_back(d);
        end
        if (id == 0) e0.push_back(r); else e1.push_back(r);
    endtask

    task automatic push_str(input int id, input string s, input int stall);
        bytes_t b;
        for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
        push_bytes(id, b, stall);
    endtask

    task automatic drive(input int n);
        drv_t it;
        bit   have = 0;
        bit   acc;
        int   stall = 0;
        forever begin
            @(negedge clk);
            acc = vld[n] && rdy[n] && !rst;
            @(posedge clk);
            #1;
            if (rst) begin
                vld[n] = 1'b0; have = 0; stall = 0;
            end else begin
                if (acc) have = 0;
                if (!have) begin
                    if (n == 0 && dq0.size() != 0) begin it = dq0.pop_front(); have = 1; stall = it.stall; end
                    if (n == 1 && dq1.size() != 0) begin it = dq1.pop_front(); have = 1; stall = it.stall; end
                end
                if (have && stall > 0) begin
                    vld[n] = 1'b0; stall--;
                end else if (have) begin
                    vld[n] = 1'b1; chr[n] = it.c; lst[n] = it.last;
                end else begin
                    vld[n] = 1'b0;
                end
            end
        end
    endtask

    initial drive(0);
    initial drive(1);

    // Monitor: round-robin pick among sources with pending strings, last winner loses ties.
    always @(negedge clk) begin
        if (rst) begin
            got_len = 0; clr_cnt = 0; m_last_id = 1'b1;
            last_res.hash = '0; last_res.id = 1'b0; last_res.len = '0; last_res.trunc = 1'b0;
        end else begin
            check("ready_exclusive", 64'(rdy[0] & rdy[1]), 64'(0));
            if (eng_valid) begin
                check("eng_valid_busy", 64'(busy), 64'(1));
                got_len++;
            end
            if (eng_clr) clr_cnt++;
            if (res_valid) begin
                if (e0.size() == 0 && e1.size() == 0) begin
                    check("res_unexpected", 64'(res_valid), 64'(0));
                end else begin
                    if (e0.size() != 0 && e1.size() != 0) m_id = ~m_last_id;
                    else m_id = (e0.size() == 0);
                    m_x = m_id ? e1.pop_front() : e0.pop_front();
                    m_x.id = m_id;
                    m_last_id = m_id;
                    check("res_id", 64'(res_id), 64'(m_x.id));
                    check("res_len", 64'(res_len), 64'(m_x.len));
                    check("res_trunc", 64'(res_trunc), 64'(m_x.trunc));
                    check("res_hash", 64'(res_hash), 64'(m_x.hash));
                    check("eng_beats", 64'(got_len), 64'(m_x.len));
                    check("eng_clr_count", 64'(clr_cnt), 64'(1));
                    last_res = m_x;
                end
                obs_id.push_back(res_id);
                got_len = 0; clr_cnt = 0;
            end else begin
                check("res_hold", 64'({res_hash, res_id, res_len, res_trunc}),
                      64'({last_res.hash, last_res.id, last_res.len, last_res.trunc}));
            end
        end
    end

    task automatic wait_done(input int max_cycles);
        int k = 0;
        while (!(dq0.size() == 0 && dq1.size() == 0 && e0.size() == 0 && e1.size() == 0 &&
                 !busy && !vld[0] && !vld[1])) begin
            @(negedge clk);
            k++;
            if (k > max_cycles) begin
                check("wait_done_timeout", 64'(k), 64'(max_cycles));
                dq0.delete(); dq1.delete(); e0.delete(); e1.delete();
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({eng_clr, eng_valid, eng_char, res_valid, res_hash, res_id, res_len,
                    res_trunc, busy, rdy[0], rdy[1]});
    endfunction

    initial begin
        logic exp_order[9];
        bytes_t b;
        int k;
        vld[0] = 1'b0; vld[1] = 1'b0; chr[0] = '0; chr[1] = '0; lst[0] = 1'b0; lst[1] = 1'b0;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[0] = '{0, "APPLES", 0, 5'd6, 1'b0};
        tbl[1] = '{1, "Q", 0, 5'd1, 1'b0};
        tbl[2] = '{0, "ABCDEFGHIJKLMNOP", 0, 5'd16, 1'b0};
        tbl[3] = '{1, "ABCDEFGHIJKLMNOPQ", 0, 5'd16, 1'b1};
        tbl[4] = '{0, "ABCDEFGHIJKLMNOPQRST", 0, 5'd16, 1'b1};
        tbl[5] = '{0, "ZT", 3, 5'd2, 1'b0};

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outputs(), 64'(0));
        @(negedge clk) rst = 1'b0;

        // Tie right after reset goes to source 0, then alternation on repeated ties.
        push_str(0, "ORANGES", 0); push_str(1, "BANANAS", 0);
        wait_done(1000);
        push_str(0, "PEARS", 0); push_str(1, "PLUMS", 0);
        wait_done(1000);
        push_str(0, "FIG", 0); push_str(0, "LIME", 0); push_str(0, "DATE", 0);
        push_str(1, "KALE", 0); push_str(1, "LEEK", 0);
        wait_done(2000);
        check("order_count", 64'(obs_id.size()), 64'(9));
        for (int i = 0; i < 9 && i < obs_id.size(); i++)
            check($sformatf("grant_order_%0d", i), 64'(obs_id[i]), 64'(exp_order[i]));

        for (int r = 0; r < 6; r++) begin
            push_str(tbl[r].id, tbl[r].s, tbl[r].stall);
            wait_done(1000);
            check($sformatf("tbl%0d_id", r), 64'(obs_id[obs_id.size() - 1]), 64'(tbl[r].id));
            check($sformatf("tbl%0d_len", r), 64'(res_len), 64'(tbl[r].exp_len));
            check($sformatf("tbl%0d_trunc", r), 64'(res_trunc), 64'(tbl[r].exp_trunc));
        end

        // Asynchronous reset in the middle of a string drops it without a result.
        push_str(1, "BANANAS", 0);
        k = 0;
        while (got_len < 3 && k < 200) begin @(negedge clk); k++; end
        check("midstring_reached", 64'(got_len >= 3), 64'(1));
        #2 rst = 1'b1;
        dq1.delete(); e1.delete();
        #1 check("midstring_reset_outputs", all_outputs(), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_str(0, "KIWI", 0);
        wait_done(1000);
        check("after_reset_id", 64'(obs_id[obs_id.size() - 1]), 64'(0));

        for (int s = 0; s < 40; s++) begin
            b.delete();
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) b.push_back(8'($urandom_range(65, 90)));
            push_bytes($urandom_range(0, 1), b, $urandom_range(0, 2));
        end
        wait_done(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
